// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
// Imported by the interface, the grant selector and the arbiter top level.
package mem_arb_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;

    // Instruction fetches always read the full 64-bit word.
    localparam logic [MASK_W-1:0] MASK_ALL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DRAIN
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        INSTR,
        DATA
    } arb_grant_t;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bundle of fetch, load/store and memory-port signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core and memory.
interface imem_dmem_arbiter_if;
    import mem_arb_pkg::*;

    logic              instr_read_in;
    logic [ADDR_W-1:0] instr_address_in;
    logic              flush_in;
    logic [DATA_W-1:0] instr_read_value_out;
    logic              instr_ready_out;

    logic              data_read_in;
    logic              data_write_in;
    logic [ADDR_W-1:0] data_address_in;
    logic [DATA_W-1:0] data_write_value_in;
    logic [MASK_W-1:0] data_write_mask_in;
    logic [DATA_W-1:0] data_read_value_out;
    logic              data_ready_out;

    logic              mem_req_out;
    logic              mem_we_out;
    logic [ADDR_W-1:0] mem_address_out;
    logic [DATA_W-1:0] mem_write_value_out;
    logic [MASK_W-1:0] mem_write_mask_out;
    logic              mem_ack_in;
    logic [DATA_W-1:0] mem_read_value_in;

    modport slave (
        input  instr_read_in, instr_address_in, flush_in,
        output instr_read_value_out, instr_ready_out,
        input  data_read_in, data_write_in, data_address_in,
        input  data_write_value_in, data_write_mask_in,
        output data_read_value_out, data_ready_out,
        output mem_req_out, mem_we_out, mem_address_out,
        output mem_write_value_out, mem_write_mask_out,
        input  mem_ack_in, mem_read_value_in
    );

    modport master (
        output instr_read_in, instr_address_in, flush_in,
        input  instr_read_value_out, instr_ready_out,
        output data_read_in, data_write_in, data_address_in,
        output data_write_value_in, data_write_mask_in,
        input  data_read_value_out, data_ready_out,
        input  mem_req_out, mem_we_out, mem_address_out,
        input  mem_write_value_out, mem_write_mask_out,
        output mem_ack_in, mem_read_value_in
    );

endinterface

// File: rtl/imem_dmem_arbiter_select.sv
// Grant selection between fetch and load/store, with a starvation counter that
// forces an instruction grant after STARVE_LIMIT back-to-back data grants.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_req,
    input  logic       data_req,
    input  logic       flush_in,
    input  logic       idle,
    output arb_grant_t grant
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] starve_cnt;
    logic       instr_ok;

    assign instr_ok = instr_req & ~flush_in;

    // Data keeps winning when no eligible fetch is waiting, even at the limit,
    // so a flushed fetch can never lock the data side out.
    always_comb begin
        grant = NONE;
        if (idle) begin
            if (data_req && ((starve_cnt < LIMIT) || !instr_ok)) begin
                grant = DATA;
            end else if (instr_ok) begin
                grant = INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else begin
            case (grant)
                DATA: begin
                    if (!instr_ok) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt < LIMIT) begin
                        starve_cnt <= starve_cnt + 3'd1;
                    end
                end
                INSTR:   starve_cnt <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one 64-bit memory port between fetch reads and load/store accesses,
// one transaction at a time, with flush-driven draining of a killed fetch.
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_dmem_arbiter_if.slave   bus
);

    arb_state_t        state;
    arb_grant_t        grant;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] mask_q;
    logic [DATA_W-1:0] instr_value_q;
    logic [DATA_W-1:0] data_value_q;
    logic              instr_ready_q;
    logic              data_ready_q;

    mem_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr_req (bus.instr_read_in),
        .data_req  (bus.data_read_in | bus.data_write_in),
        .flush_in  (bus.flush_in),
        .idle      (state == IDLE),
        .grant     (grant)
    );

    // Address, data and mask keep their last values once the port goes idle.
    assign bus.mem_req_out          = req_q;
    assign bus.mem_we_out           = req_q & we_q;
    assign bus.mem_address_out      = addr_q;
    assign bus.mem_write_value_out  = wdata_q;
    assign bus.mem_write_mask_out   = mask_q;
    assign bus.instr_read_value_out = instr_value_q;
    assign bus.instr_ready_out      = instr_ready_q;
    assign bus.data_read_value_out  = data_value_q;
    assign bus.data_ready_out       = data_ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            mask_q        <= '0;
            instr_value_q <= '0;
            data_value_q  <= '0;
            instr_ready_q <= 1'b0;
            data_ready_q  <= 1'b0;
        end else begin
            instr_ready_q <= 1'b0;
            data_ready_q  <= 1'b0;
            case (state)
                IDLE: begin
                    case (grant)
                        INSTR: begin
                            addr_q  <= bus.instr_address_in;
                            wdata_q <= '0;
                            mask_q  <= MASK_ALL;
                            we_q    <= 1'b0;
                            req_q   <= 1'b1;
                            state   <= BUSY_I;
                        end
                        DATA: begin
                            addr_q  <= bus.data_address_in;
                            wdata_q <= bus.data_write_value_in;
                            mask_q  <= bus.data_write_mask_in;
                            we_q    <= bus.data_write_in;
                            req_q   <= 1'b1;
                            state   <= BUSY_D;
                        end
                        default: ;
                    endcase
                end
                // A flush coinciding with the ack completes the bus cycle silently.
                BUSY_I: begin
                    if (bus.mem_ack_in) begin
                        req_q <= 1'b0;
                        state <= IDLE;
                        if (!bus.flush_in) begin
                            instr_value_q <= bus.mem_read_value_in;
                            instr_ready_q <= 1'b1;
                        end
                    end else if (bus.flush_in) begin
                        state <= DRAIN;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ack_in) begin
                        req_q        <= 1'b0;
                        we_q         <= 1'b0;
                        data_value_q <= we_q ? '0 : bus.mem_read_value_in;
                        data_ready_q <= 1'b1;
                        state        <= IDLE;
                    end
                end
                DRAIN: begin
                    if (bus.mem_ack_in) begin
                        req_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed self-checking bench for imem_dmem_arbiter; inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_imem_dmem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    imem_dmem_arbiter_if bus();

    imem_dmem_arbiter #(
        .STARVE_LIMIT(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic ir, input logic [63:0] ia, input logic dr,
                                  input logic dw, input logic [63:0] da,
                                  input logic [63:0] dv, input logic [7:0] dm,
                                  input logic fl);
        bus.instr_read_in       = ir;
        bus.instr_address_in    = ia;
        bus.data_read_in        = dr;
        bus.data_write_in       = dw;
        bus.data_address_in     = da;
        bus.data_write_value_in = dv;
        bus.data_write_mask_in  = dm;
        bus.flush_in            = fl;
    endtask

    // Expects the port to be busy now: checks request and address, acks this cycle.
    task automatic one_txn(input string tag, input logic [63:0] exp_addr, input logic [63:0] rdata);
        check_output({tag, "_req"}, 64'(bus.mem_req_out), 64'd1);
        check_output({tag, "_addr"}, bus.mem_address_out, exp_addr);
        bus.mem_ack_in        = 1'b1;
        bus.mem_read_value_in = rdata;
        tick();
        bus.mem_ack_in        = 1'b0;
    endtask

    initial begin
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_ack_in        = 1'b0;
        bus.mem_read_value_in = '0;

        rst_n = 1'b0;
        tick();
        tick();
        check_output("rst_req",      64'(bus.mem_req_out), 64'd0);
        check_output("rst_we",       64'(bus.mem_we_out), 64'd0);
        check_output("rst_addr",     bus.mem_address_out, 64'd0);
        check_output("rst_mask",     64'(bus.mem_write_mask_out), 64'd0);
        check_output("rst_iready",   64'(bus.instr_ready_out), 64'd0);
        check_output("rst_dready",   64'(bus.data_ready_out), 64'd0);
        check_output("rst_ivalue",   bus.instr_read_value_out, 64'd0);
        rst_n = 1'b1;
        tick();

        // Single fetch, zero wait states
        apply_stimulus(1, 64'h1000, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("fetch_we",   64'(bus.mem_we_out), 64'd0);
        check_output("fetch_mask", 64'(bus.mem_write_mask_out), 64'hFF);
        one_txn("fetch", 64'h1000, 64'hDEADBEEF_00000013);
        check_output("fetch_iready", 64'(bus.instr_ready_out), 64'd1);
        check_output("fetch_ivalue", bus.instr_read_value_out, 64'hDEADBEEF_00000013);
        check_output("fetch_dready", 64'(bus.data_ready_out), 64'd0);
        check_output("fetch_req_idle", 64'(bus.mem_req_out), 64'd0);
        bus.instr_read_in = 1'b0;
        tick();
        check_output("fetch_pulse_end", 64'(bus.instr_ready_out), 64'd0);
        check_output("fetch_no_regrant", 64'(bus.mem_req_out), 64'd0);

        // Simultaneous fetch and load: data first
        apply_stimulus(1, 64'h1100, 1, 0, 64'h2000, 0, 0, 0);
        tick();
        check_output("simul_we", 64'(bus.mem_we_out), 64'd0);
        one_txn("simul_d", 64'h2000, 64'hAAAA_0000_1111_2222);
        check_output("simul_dready", 64'(bus.data_ready_out), 64'd1);
        check_output("simul_dvalue", bus.data_read_value_out, 64'hAAAA_0000_1111_2222);
        check_output("simul_iready0", 64'(bus.instr_ready_out), 64'd0);
        bus.data_read_in = 1'b0;
        tick();
        one_txn("simul_i", 64'h1100, 64'h0000_0000_0000_0093);
        check_output("simul_iready", 64'(bus.instr_ready_out), 64'd1);
        check_output("simul_ivalue", bus.instr_read_value_out, 64'h93);
        bus.instr_read_in = 1'b0;
        tick();

        // Starvation: data held continuously, fetch waiting
        apply_stimulus(1, 64'h1000, 1, 0, 64'h2000, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            one_txn($sformatf("starve_d%0d", i), 64'h2000, 64'(i));
            check_output($sformatf("starve_dready%0d", i), 64'(bus.data_ready_out), 64'd1);
            check_output($sformatf("starve_iready%0d", i), 64'(bus.instr_ready_out), 64'd0);
            tick();
        end
        one_txn("starve_i", 64'h1000, 64'h77);
        check_output("starve_iready", 64'(bus.instr_ready_out), 64'd1);
        bus.instr_read_in = 1'b0;
        tick();
        one_txn("starve_resume", 64'h2000, 64'h88);
        check_output("starve_resume_dready", 64'(bus.data_ready_out), 64'd1);
        bus.data_read_in = 1'b0;
        tick();
        check_output("starve_idle", 64'(bus.mem_req_out), 64'd0);

        // Flush while the fetch waits on a slow memory
        apply_stimulus(1, 64'h4000, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("flush_req_c1", 64'(bus.mem_req_out), 64'd1);
        tick();
        bus.flush_in      = 1'b1;
        bus.instr_read_in = 1'b0;
        check_output("flush_req_c2", 64'(bus.mem_req_out), 64'd1);
        tick();
        bus.flush_in = 1'b0;
        bus.data_read_in    = 1'b1;
        bus.data_address_in = 64'h5000;
        check_output("drain_req_c3", 64'(bus.mem_req_out), 64'd1);
        check_output("drain_iready_c3", 64'(bus.instr_ready_out), 64'd0);
        tick();
        check_output("drain_req_c4", 64'(bus.mem_req_out), 64'd1);
        check_output("drain_addr_c4", bus.mem_address_out, 64'h4000);
        tick();
        check_output("drain_req_c5", 64'(bus.mem_req_out), 64'd1);
        bus.mem_ack_in        = 1'b1;
        bus.mem_read_value_in = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        bus.mem_ack_in = 1'b0;
        check_output("drain_iready", 64'(bus.instr_ready_out), 64'd0);
        check_output("drain_dready", 64'(bus.data_ready_out), 64'd0);
        check_output("drain_req_done", 64'(bus.mem_req_out), 64'd0);
        tick();
        one_txn("flush_next", 64'h5000, 64'h1234);
        check_output("flush_next_dready", 64'(bus.data_ready_out), 64'd1);
        check_output("flush_next_dvalue", bus.data_read_value_out, 64'h1234);
        bus.data_read_in = 1'b0;
        tick();

        // Flush in the same cycle as the fetch ack
        apply_stimulus(1, 64'h6000, 0, 0, 0, 0, 0, 0);
        tick();
        bus.flush_in          = 1'b1;
        bus.instr_read_in     = 1'b0;
        bus.mem_ack_in        = 1'b1;
        bus.mem_read_value_in = 64'h6666;
        tick();
        bus.mem_ack_in = 1'b0;
        bus.flush_in   = 1'b0;
        check_output("flushack_iready", 64'(bus.instr_ready_out), 64'd0);
        check_output("flushack_req", 64'(bus.mem_req_out), 64'd0);
        tick();
        check_output("flushack_no_late", 64'(bus.instr_ready_out), 64'd0);

        // Flush in IDLE makes the fetch ineligible for that cycle
        apply_stimulus(1, 64'h9000, 0, 0, 0, 0, 0, 1);
        tick();
        check_output("idleflush_req", 64'(bus.mem_req_out), 64'd0);
        bus.flush_in = 1'b0;
        tick();
        one_txn("idleflush_fetch", 64'h9000, 64'h9999);
        check_output("idleflush_iready", 64'(bus.instr_ready_out), 64'd1);
        bus.instr_read_in = 1'b0;
        tick();

        // Store: write enable, data and mask on the port, zero read value
        apply_stimulus(0, 0, 0, 1, 64'h3008, 64'h55, 8'h0F, 0);
        tick();
        check_output("store_we",    64'(bus.mem_we_out), 64'd1);
        check_output("store_value", bus.mem_write_value_out, 64'h55);
        check_output("store_mask",  64'(bus.mem_write_mask_out), 64'h0F);
        one_txn("store", 64'h3008, 64'hFFFF_FFFF_FFFF_FFFF);
        check_output("store_dready", 64'(bus.data_ready_out), 64'd1);
        check_output("store_dvalue", bus.data_read_value_out, 64'd0);
        bus.data_write_in = 1'b0;
        tick();
        check_output("store_we_idle",   64'(bus.mem_we_out), 64'd0);
        check_output("store_addr_hold", bus.mem_address_out, 64'h3008);
        check_output("store_mask_hold", 64'(bus.mem_write_mask_out), 64'h0F);

        // Reset while a load is outstanding
        apply_stimulus(0, 0, 1, 0, 64'h7000, 0, 0, 0);
        tick();
        check_output("rstbusy_req", 64'(bus.mem_req_out), 64'd1);
        rst_n = 1'b0;
        bus.data_read_in = 1'b0;
        tick();
        rst_n = 1'b1;
        check_output("rstbusy_req_drop", 64'(bus.mem_req_out), 64'd0);
        check_output("rstbusy_dready", 64'(bus.data_ready_out), 64'd0);
        check_output("rstbusy_iready", 64'(bus.instr_ready_out), 64'd0);
        check_output("rstbusy_addr", bus.mem_address_out, 64'd0);
        apply_stimulus(1, 64'h8000, 0, 0, 0, 0, 0, 0);
        tick();
        one_txn("rstbusy_fetch", 64'h8000, 64'hCAFE_F00D_0000_0001);
        check_output("rstbusy_fetch_iready", 64'(bus.instr_ready_out), 64'd1);
        check_output("rstbusy_fetch_ivalue", bus.instr_read_value_out, 64'hCAFE_F00D_0000_0001);
        bus.instr_read_in = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
